// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue feeding the IF/ID register.
// Issues in-order fetches to a variable-latency instruction memory, buffers
// returned {pc+4, instr} pairs in a DEPTH-entry ring and hands them to the
// pipeline. A redirect from MEM flushes the ring and arranges for every
// response still in flight to be dropped when it eventually returns.
//
// Handshakes:
//   memory request : a request transfers on a rising edge where
//                    imem_req_o && imem_ready_i; address is stable while
//                    imem_req_o is high.
//   memory response: one response per imem_rvalid_i cycle, returned in
//                    request order, never in the same cycle as its request.
//   pipeline output: an entry transfers on a rising edge where
//                    valid_o && ready_i; with ready_i low, valid_o, pc4_o
//                    and instr_o hold stable.
module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] pc4_o,
    output logic [31:0] instr_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = $clog2(2 * DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Ring storage; only the filled flags need a reset value because the
    // outputs are forced to zero whenever the head is not filled.
    logic [31:0]      pc4_mem   [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [DEPTH-1:0] filled;
    logic [DEPTH-1:0] filled_next;

    // head: next entry handed to the pipeline
    // tail: oldest entry still waiting for its memory response
    // alloc: next entry reserved by a new request
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] alloc;

    logic [31:0]   fetch_pc;
    logic [CW-1:0] count;        // entries reserved (filled or awaiting data)
    logic [CW-1:0] count_next;
    logic [CW-1:0] outstanding;  // accepted requests whose data will be kept
    logic [CW-1:0] outstanding_next;
    logic [DW-1:0] discard;      // responses still to arrive that must be dropped
    logic [DW-1:0] discard_redirect;

    logic issue;
    logic resp_drop;
    logic resp_fill;
    logic pop;
    logic rvalid_owned;

    // Request side: hold off while the ring is fully reserved, during a
    // redirect, and while reset is asserted.
    assign imem_req_o  = rst_i && (count < DEPTH_C) && !redirect_i;
    assign imem_addr_o = fetch_pc;
    assign issue       = imem_req_o && imem_ready_i;

    // Response side: pending discards are consumed first; a response with
    // nothing outstanding and nothing to discard is spurious and ignored.
    assign resp_drop    = imem_rvalid_i && (discard != '0) && !redirect_i;
    assign resp_fill    = imem_rvalid_i && (discard == '0) && (outstanding != '0)
                          && !redirect_i;
    assign rvalid_owned = imem_rvalid_i && ((discard != '0) || (outstanding != '0));

    // Output side: a pop coinciding with a redirect is ignored.
    assign valid_o = filled[head];
    assign pop     = valid_o && ready_i && !redirect_i;
    assign pc4_o   = valid_o ? pc4_mem[head] : 32'h0;
    assign instr_o = valid_o ? instr_mem[head] : 32'h0;

    // Net counter updates when issue, response and pop coincide.
    always_comb begin
        count_next       = count + CW'(issue) - CW'(pop);
        outstanding_next = outstanding + CW'(issue) - CW'(resp_fill);
        // A response arriving in the redirect cycle is itself one of the
        // stale ones, so it is taken off the discard total right away.
        discard_redirect = discard + DW'(outstanding) - DW'(rvalid_owned);
    end

    // Next filled flags: pop clears head, response sets tail, a fresh
    // reservation starts empty; a redirect invalidates everything.
    always_comb begin
        filled_next = filled;
        if (pop) begin
            filled_next[head] = 1'b0;
        end
        if (resp_fill) begin
            filled_next[tail] = 1'b1;
        end
        if (issue) begin
            filled_next[alloc] = 1'b0;
        end
        if (redirect_i) begin
            filled_next = '0;
        end
    end

    // Filled flags register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            filled <= '0;
        end else begin
            filled <= filled_next;
        end
    end

    // Pointer, counter and fetch address registers; redirect dominates.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_pc    <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            alloc       <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect_i) begin
            fetch_pc    <= redirect_pc_i;
            head        <= '0;
            tail        <= '0;
            alloc       <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= discard_redirect;
        end else begin
            if (issue) begin
                alloc    <= alloc + 1'b1;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (resp_drop) begin
                discard <= discard - 1'b1;
            end
            if (resp_fill) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count       <= count_next;
            outstanding <= outstanding_next;
        end
    end

    // Payload storage: pc+4 written at reservation, instruction at response.
    always_ff @(posedge clk_i) begin
        if (issue) begin
            pc4_mem[alloc] <= fetch_pc + 32'd4;
        end
        if (resp_fill) begin
            instr_mem[tail] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: a fixed-latency memory model returns
// addr|0xA000_0000 for each accepted fetch, and each scenario checks the
// output/request values hand-derived cycle by cycle from reset release (c0).
module tb_if_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i = 1'b1;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] pc4_o;
    logic [31:0] instr_o;

    int checks   = 0;
    int failures = 0;
    int mem_lat  = 1;
    int cyc      = 0;
    int acc_cnt  = 0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .pc4_o         (pc4_o),
        .instr_o       (instr_o)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: responses driven 1 time unit after the edge, accepted
    // requests recorded mid-cycle with their due cycle. Pending responses
    // survive reset so pre-reset requests can come back as strays.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = pend_addr[0] | 32'hA000_0000;
                pend_addr.delete(0);
                pend_due.delete(0);
            end
            @(negedge clk);
            if (!rst_i) begin
                acc_cnt = 0;
            end else if (imem_req_o && imem_ready_i) begin
                pend_addr.push_back(imem_addr_o);
                pend_due.push_back(cyc + mem_lat);
                acc_cnt++;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Hold reset long enough for any in-flight responses to drain, then
    // release; the caller is left in cycle c0 just after the edge.
    task automatic do_reset(input int lat, input logic rdy);
        rst_i         = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        ready_i       = rdy;
        mem_lat       = lat;
        repeat (5) next_cycle();
        rst_i = 1'b1;
    endtask

    initial begin
        // Reset values
        repeat (3) next_cycle();
        settle();
        check("rst_valid", {31'h0, valid_o}, 32'h0);
        check("rst_pc4", pc4_o, 32'h0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_req", {31'h0, imem_req_o}, 32'h0);

        // 1: streaming with 1-cycle memory, pipeline always ready
        do_reset(1, 1'b1);
        settle();
        check("t1_c0_req", {31'h0, imem_req_o}, 32'h1);
        check("t1_c0_addr", imem_addr_o, 32'h0);
        check("t1_c0_valid", {31'h0, valid_o}, 32'h0);
        next_cycle(); settle();
        check("t1_c1_addr", imem_addr_o, 32'h4);
        check("t1_c1_valid", {31'h0, valid_o}, 32'h0);
        next_cycle(); settle();
        check("t1_c2_valid", {31'h0, valid_o}, 32'h1);
        check("t1_c2_pc4", pc4_o, 32'h4);
        check("t1_c2_instr", instr_o, 32'hA000_0000);
        check("t1_c2_addr", imem_addr_o, 32'h8);
        for (int k = 1; k <= 4; k++) begin
            next_cycle(); settle();
            check("t1_stream_valid", {31'h0, valid_o}, 32'h1);
            check("t1_stream_pc4", pc4_o, 32'h4 + 32'(4 * k));
            check("t1_stream_instr", instr_o, 32'hA000_0000 + 32'(4 * k));
        end

        // 2: backpressure fills the ring, then release
        do_reset(1, 1'b0);
        settle();
        repeat (10) next_cycle();
        settle();
        check("t2_accepts", 32'(acc_cnt), 32'd4);
        check("t2_req_full", {31'h0, imem_req_o}, 32'h0);
        check("t2_hold_valid", {31'h0, valid_o}, 32'h1);
        check("t2_hold_pc4", pc4_o, 32'h4);
        check("t2_hold_instr", instr_o, 32'hA000_0000);
        ready_i = 1'b1;
        #1;
        check("t2_req_pop_cycle", {31'h0, imem_req_o}, 32'h0);
        next_cycle(); settle();
        check("t2_req_resume", {31'h0, imem_req_o}, 32'h1);
        check("t2_addr_resume", imem_addr_o, 32'h10);
        check("t2_pc4_next", pc4_o, 32'h8);
        check("t2_instr_next", instr_o, 32'hA000_0004);

        // 3: latency 3, redirect with three requests in flight
        do_reset(3, 1'b1);
        settle();
        check("t3_c0_addr", imem_addr_o, 32'h0);
        next_cycle(); next_cycle(); next_cycle();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0100;
        settle();
        check("t3_redir_req", {31'h0, imem_req_o}, 32'h0);
        next_cycle();
        redirect_i = 1'b0;
        settle();
        check("t3_c4_valid", {31'h0, valid_o}, 32'h0);
        check("t3_c4_req", {31'h0, imem_req_o}, 32'h1);
        check("t3_c4_addr", imem_addr_o, 32'h0000_0100);
        next_cycle(); settle();
        check("t3_c5_valid", {31'h0, valid_o}, 32'h0);
        next_cycle(); next_cycle(); settle();
        check("t3_c7_valid", {31'h0, valid_o}, 32'h0);
        next_cycle(); settle();
        check("t3_c8_valid", {31'h0, valid_o}, 32'h1);
        check("t3_c8_pc4", pc4_o, 32'h0000_0104);
        check("t3_c8_instr", instr_o, 32'hA000_0100);
        next_cycle(); settle();
        check("t3_c9_pc4", pc4_o, 32'h0000_0108);
        check("t3_c9_instr", instr_o, 32'hA000_0104);

        // 4: redirect together with a response and a pop
        do_reset(2, 1'b1);
        next_cycle(); next_cycle(); settle();
        check("t4_c2_valid", {31'h0, valid_o}, 32'h0);
        next_cycle();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        settle();
        check("t4_c3_rvalid_present", {31'h0, imem_rvalid_i}, 32'h1);
        check("t4_c3_valid", {31'h0, valid_o}, 32'h1);
        check("t4_c3_pc4", pc4_o, 32'h4);
        next_cycle();
        redirect_i = 1'b0;
        settle();
        check("t4_c4_valid", {31'h0, valid_o}, 32'h0);
        check("t4_c4_addr", imem_addr_o, 32'h0000_0200);
        next_cycle(); settle();
        check("t4_c5_valid", {31'h0, valid_o}, 32'h0);
        next_cycle(); settle();
        check("t4_c6_valid", {31'h0, valid_o}, 32'h0);
        next_cycle(); settle();
        check("t4_c7_valid", {31'h0, valid_o}, 32'h1);
        check("t4_c7_pc4", pc4_o, 32'h0000_0204);
        check("t4_c7_instr", instr_o, 32'hA000_0200);

        // 5: fetch address wraps past 0xFFFF_FFFC
        do_reset(1, 1'b1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        settle();
        check("t5_c0_req", {31'h0, imem_req_o}, 32'h0);
        next_cycle();
        redirect_i = 1'b0;
        settle();
        check("t5_c1_addr", imem_addr_o, 32'hFFFF_FFFC);
        next_cycle(); settle();
        check("t5_c2_addr", imem_addr_o, 32'h0000_0000);
        next_cycle(); settle();
        check("t5_c3_valid", {31'h0, valid_o}, 32'h1);
        check("t5_c3_pc4", pc4_o, 32'h0000_0000);
        check("t5_c3_instr", instr_o, 32'hFFFF_FFFC);
        next_cycle(); settle();
        check("t5_c4_pc4", pc4_o, 32'h0000_0004);
        check("t5_c4_instr", instr_o, 32'hA000_0000);

        // 6: reset mid-stream with two requests outstanding
        do_reset(2, 1'b1);
        settle();
        check("t6_c0_addr", imem_addr_o, 32'h0);
        next_cycle(); settle();
        check("t6_c1_addr", imem_addr_o, 32'h4);
        next_cycle();
        rst_i = 1'b0;
        settle();
        check("t6_rst_valid", {31'h0, valid_o}, 32'h0);
        check("t6_rst_pc4", pc4_o, 32'h0);
        check("t6_rst_instr", instr_o, 32'h0);
        check("t6_rst_req", {31'h0, imem_req_o}, 32'h0);
        next_cycle();
        rst_i = 1'b1;
        settle();
        check("t6_r0_stray_present", {31'h0, imem_rvalid_i}, 32'h1);
        check("t6_r0_req", {31'h0, imem_req_o}, 32'h1);
        check("t6_r0_addr", imem_addr_o, 32'h0);
        check("t6_r0_valid", {31'h0, valid_o}, 32'h0);
        next_cycle(); settle();
        check("t6_r1_valid", {31'h0, valid_o}, 32'h0);
        check("t6_r1_addr", imem_addr_o, 32'h4);
        next_cycle(); settle();
        check("t6_r2_valid", {31'h0, valid_o}, 32'h0);
        next_cycle(); settle();
        check("t6_r3_valid", {31'h0, valid_o}, 32'h1);
        check("t6_r3_pc4", pc4_o, 32'h4);
        check("t6_r3_instr", instr_o, 32'hA000_0000);
        next_cycle(); settle();
        check("t6_r4_pc4", pc4_o, 32'h8);
        check("t6_r4_instr", instr_o, 32'hA000_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
Instruction prefetch unit sitting directly upstream of the IF/ID pipeline register. It replaces the bare PC/adder/instruction-memory path with a decoupled fetcher. It issues in-order requests to a variable-latency instruction memory and buffers the returned {pc+4, instruction} pairs in a small ring buffer. It presents them to the pipeline with a valid/ready handshake; a taken branch from the MEM stage redirects it, flushing the buffer and discarding in-flight responses.

Parameters:
DEPTH, 4, ring-buffer entries and maximum outstanding requests (power of 2, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  reset
imem_req_o  output  1  fetch request valid
imem_addr_o  output  32  fetch address (word aligned)
imem_ready_i  input  1  memory accepts request this cycle
imem_rvalid_i  input  1  response valid (in request order)
imem_rdata_i  input  32  response instruction
redirect_i  input  1  taken branch/jump from MEM stage
redirect_pc_i  input  32  branch target
valid_o  output  1  head entry holds a returned instruction
ready_i  input  1  pipeline consumes head (IF/ID write enable)
pc4_o  output  32  pc+4 of head instruction
instr_o  output  32  head instruction

Behaviour:
- Reset is asynchronous and active-low (rst_i=0 resets), single clock clk_i.
- Reset values:
  - fetch_pc=RESET_PC; head/tail/alloc pointers=0; count=0; outstanding=0; discard=0.
  - valid_o=0, pc4_o=0, instr_o=0 (NOP).
  - imem_req_o rises on the first cycle after reset release.
- Storage: DEPTH entries of {pc4[31:0], instr[31:0], filled}. Counter width is clog2(DEPTH+1).
- Issue:
  - imem_req_o = (allocated < DEPTH) && !redirect_i.
  - allocated = entries reserved, whether filled or awaiting a response.
  - imem_addr_o = fetch_pc.
  - Request is accepted when imem_req_o && imem_ready_i. On acceptance:
    - entry[alloc] gets pc4=fetch_pc+4 and filled=0;
    - alloc advances;
    - fetch_pc += 4 (wraps modulo 2^32);
    - outstanding increments.
- Response:
  - When imem_rvalid_i and discard>0: discard decrements and data is dropped.
  - Otherwise, the oldest unfilled entry gets instr=imem_rdata_i and filled=1, and outstanding decrements.
  - Zero-latency responses are not supported: a response is never consumed in its own issue cycle.
- Output:
  - valid_o = head entry filled.
  - pc4_o/instr_o are driven from the head entry when valid_o=1, and are 0 otherwise.
  - A pop occurs when valid_o && ready_i; head advances and allocated decrements.
  - With ready_i=0 the outputs hold stable.
- Simultaneous issue, response and pop in one cycle all take effect; allocated is net-updated.
- Redirect (redirect_i=1), which has priority over everything:
  - All entries are invalidated; head=tail=alloc; count=0.
  - fetch_pc <= redirect_pc_i.
  - discard <= discard + outstanding - (1 if imem_rvalid_i this cycle).
  - outstanding <= 0.
  - A pop in the same cycle is ignored, and a response in the same cycle is dropped.
  - No request is issued in the redirect cycle. The target is requested the next cycle; valid_o is 0 on that cycle.
- Spurious response (imem_rvalid_i with outstanding==0 and discard==0) is ignored with no state change.
- Invariant: allocated <= DEPTH. outstanding + discard <= 2*DEPTH, and the discard counter is sized clog2(2*DEPTH+1).
- Reset mid-operation: everything returns to reset values immediately. Responses arriving after reset release for pre-reset requests are treated as spurious.
- Latency: best case, valid_o is asserted 1 cycle after a 1-cycle memory response. Throughput is 1 instruction/cycle when memory streams.

Test Plan:
1. Reset release, memory ready and responding with 1-cycle latency with data=addr|0xA000_0000 -> requests 0x0,0x4,0x8..., then valid_o with pc4_o=0x4, instr_o=0xA000_0000, then one pop per cycle with pc4_o incrementing by 4.
2. ready_i=0 for 10 cycles while streaming -> exactly DEPTH=4 requests issued, imem_req_o=0 afterwards, outputs held at pc4_o=0x4; raising ready_i resumes issue the cycle after the first pop.
3. Memory latency 3 cycles with 3 outstanding, then redirect_i=1 with redirect_pc_i=0x100 -> valid_o=0 next cycle, the 3 stale responses are dropped, the next request address is 0x100, and the first valid output is pc4_o=0x104.
4. Redirect coincident with imem_rvalid_i and ready_i pop -> the response is dropped, the head is not re-presented, and discard equals outstanding-1.
5. fetch_pc=0xFFFF_FFFC -> the following request address wraps to 0x0000_0000 and pc4_o=0x0000_0000 for that instruction.
6. rst_i asserted low mid-stream with 2 outstanding -> immediate reset values; post-release stray responses are ignored and fetch restarts at RESET_PC.
